// File: rtl/flash_audio_pkg.sv
// ============================================================================
// Module : flash_audio_pkg
// Brief  : Shared state encoding and slot sizing helpers for the flash audio
//          streamer and its address generator.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package flash_audio_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_SAMPLE_W = 16;
    localparam int DEF_ADDR_W   = 23;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_WAIT_DATA = 3'd2,
        ST_READY     = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    function automatic int slot_count(input int data_w, input int sample_w);
        return data_w / sample_w;
    endfunction

    // A single-slot word still needs a one-bit slot register.
    function automatic int slot_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/flash_addr_gen.sv
// ============================================================================
// Module : flash_addr_gen
// Brief  : Flash word-address register with up/down step, window wrap and an
//          end-of-window flag for the playback controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module flash_addr_gen #(
    parameter int                ADDR_W     = 23,
    parameter logic [ADDR_W-1:0] START_ADDR = '0,
    parameter logic [ADDR_W-1:0] END_ADDR   = '1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_rewind,
    input  logic              i_step,
    input  logic              i_dir,
    input  logic              i_loop,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_end_of_window
);

    localparam logic [ADDR_W-1:0] c_addr_one = ADDR_W'(1);

    logic [ADDR_W-1:0] r_addr;
    logic              w_at_edge;

    // Next step in the requested direction would leave the window.
    assign w_at_edge       = i_dir ? (r_addr == START_ADDR) : (r_addr == END_ADDR);
    assign o_end_of_window = w_at_edge & ~i_loop;
    assign o_addr          = r_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr <= START_ADDR;
        end else if (i_rewind) begin
            r_addr <= i_dir ? END_ADDR : START_ADDR;
        end else if (i_step && !o_end_of_window) begin
            if (w_at_edge) begin
                r_addr <= i_dir ? END_ADDR : START_ADDR;
            end else if (i_dir) begin
                r_addr <= r_addr - c_addr_one;
            end else begin
                r_addr <= r_addr + c_addr_one;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/flash_audio_streamer.sv
// ============================================================================
// Module : flash_audio_streamer
// Brief  : Reads packed audio words from flash one at a time and plays their
//          sample slots forward or reverse on a level-sensitive sample tick.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module flash_audio_streamer
    import flash_audio_pkg::*;
#(
    parameter int                DATA_W     = DEF_DATA_W,
    parameter int                SAMPLE_W   = DEF_SAMPLE_W,
    parameter int                ADDR_W     = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] START_ADDR = '0,
    parameter logic [ADDR_W-1:0] END_ADDR   = '1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_tick,
    input  logic                play,
    input  logic                reverse,
    input  logic                loop,
    input  logic                restart,
    output logic                flsh_read,
    output logic [ADDR_W-1:0]   flsh_address,
    output logic [DATA_W/8-1:0] flsh_byteenable,
    input  logic                flsh_waitrequest,
    input  logic [DATA_W-1:0]   flsh_readdata,
    input  logic                flsh_readdatavalid,
    output logic [SAMPLE_W-1:0] audio_out,
    output logic                audio_enable,
    output logic                done,
    output logic                underrun
);

    localparam int                  c_n         = slot_count(DATA_W, SAMPLE_W);
    localparam int                  c_slot_w    = slot_width(c_n);
    localparam logic [c_slot_w-1:0] c_last_slot = c_slot_w'(c_n - 1);
    localparam logic [c_slot_w-1:0] c_slot_one  = c_slot_w'(1);

    state_t                r_state;
    state_t                w_next;
    logic [DATA_W-1:0]     r_word;
    logic [c_slot_w-1:0]   r_slot;
    logic                  r_dir;
    logic                  r_restart_pend;
    logic [SAMPLE_W-1:0]   r_audio_out;
    logic                  r_audio_enable;
    logic                  r_underrun;
    logic                  w_rewind;
    logic                  w_capture;
    logic                  w_consume;
    logic                  w_step;
    logic                  w_last_slot;
    logic                  w_end_of_window;
    logic                  w_busy;
    logic [SAMPLE_W-1:0]   w_sample;
    logic [SAMPLE_W-1:0]   w_slots [c_n];

    for (genvar gi = 0; gi < c_n; gi++) begin : g_slots
        assign w_slots[gi] = r_word[gi*SAMPLE_W +: SAMPLE_W];
    end

    assign w_sample    = w_slots[r_slot];
    assign w_last_slot = r_dir ? (r_slot == '0) : (r_slot == c_last_slot);
    assign w_busy      = (r_state == ST_FETCH) || (r_state == ST_WAIT_DATA);

    flash_addr_gen #(
        .ADDR_W     (ADDR_W),
        .START_ADDR (START_ADDR),
        .END_ADDR   (END_ADDR)
    ) u_addr_gen (
        .clk             (clk),
        .rst             (rst),
        .i_rewind        (w_rewind),
        .i_step          (w_step),
        .i_dir           (reverse),
        .i_loop          (loop),
        .o_addr          (flsh_address),
        .o_end_of_window (w_end_of_window)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_rewind  = 1'b0;
        w_capture = 1'b0;
        w_consume = 1'b0;
        w_step    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (restart) begin
                    w_rewind = 1'b1;
                end else if (play) begin
                    w_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (!flsh_waitrequest) begin
                    w_next = ST_WAIT_DATA;
                end
            end
            ST_WAIT_DATA: begin
                // A restart seen during the read throws the returned word away.
                if (flsh_readdatavalid) begin
                    if (r_restart_pend || restart) begin
                        w_rewind = 1'b1;
                        w_next   = ST_IDLE;
                    end else begin
                        w_capture = 1'b1;
                        w_next    = ST_READY;
                    end
                end
            end
            ST_READY: begin
                if (restart) begin
                    w_rewind = 1'b1;
                    w_next   = ST_IDLE;
                end else if (sample_tick && play) begin
                    w_consume = 1'b1;
                    if (w_last_slot) begin
                        w_step = 1'b1;
                        w_next = w_end_of_window ? ST_DONE : ST_FETCH;
                    end
                end
            end
            ST_DONE: begin
                if (restart) begin
                    w_rewind = 1'b1;
                    w_next   = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word         <= '0;
            r_slot         <= '0;
            r_dir          <= 1'b0;
            r_restart_pend <= 1'b0;
            r_audio_out    <= '0;
            r_audio_enable <= 1'b0;
            r_underrun     <= 1'b0;
        end else begin
            r_audio_enable <= w_consume;
            if (w_consume) begin
                r_audio_out <= w_sample;
                r_slot      <= r_dir ? (r_slot - c_slot_one) : (r_slot + c_slot_one);
            end
            if (w_capture) begin
                r_word <= flsh_readdata;
                r_dir  <= reverse;
                r_slot <= reverse ? c_last_slot : '0;
            end
            if (w_rewind) begin
                r_word <= '0;
                r_slot <= '0;
            end
            if (w_rewind) begin
                r_restart_pend <= 1'b0;
            end else if (restart && w_busy) begin
                r_restart_pend <= 1'b1;
            end
            if (w_busy && sample_tick && play) begin
                r_underrun <= 1'b1;
            end
        end
    end

    assign flsh_read       = (r_state == ST_FETCH);
    assign flsh_byteenable = '1;
    assign audio_out       = r_audio_out;
    assign audio_enable    = r_audio_enable;
    assign done            = (r_state == ST_DONE);
    assign underrun        = r_underrun;

endmodule

`default_nettype wire

// File: tb/tb_flash_audio_streamer.sv
// ============================================================================
// Module : tb_flash_audio_streamer
// Brief  : Self-checking bench: directed playback scenarios followed by random
//          stimulus, compared every cycle against a sample-queue model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_flash_audio_streamer;

    localparam int             DW    = 32;
    localparam int             SW    = 16;
    localparam int             AW    = 23;
    localparam int             NS    = DW / SW;
    localparam logic [AW-1:0]  START = 23'd0;
    localparam logic [AW-1:0]  ENDA  = 23'd3;

    logic            clk;
    logic            rst;
    logic            sample_tick, play, reverse, loop, restart;
    logic            flsh_read;
    logic [AW-1:0]   flsh_address;
    logic [DW/8-1:0] flsh_byteenable;
    logic            flsh_waitrequest;
    logic [DW-1:0]   flsh_readdata;
    logic            flsh_readdatavalid;
    logic [SW-1:0]   audio_out;
    logic            audio_enable, done, underrun;

    flash_audio_streamer #(
        .DATA_W(DW), .SAMPLE_W(SW), .ADDR_W(AW), .START_ADDR(START), .END_ADDR(ENDA)
    ) dut (
        .clk(clk), .rst(rst), .sample_tick(sample_tick), .play(play), .reverse(reverse),
        .loop(loop), .restart(restart), .flsh_read(flsh_read), .flsh_address(flsh_address),
        .flsh_byteenable(flsh_byteenable), .flsh_waitrequest(flsh_waitrequest),
        .flsh_readdata(flsh_readdata), .flsh_readdatavalid(flsh_readdatavalid),
        .audio_out(audio_out), .audio_enable(audio_enable), .done(done), .underrun(underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_rd_cyc, n_acc, n_en;

    logic [DW-1:0] mem [4];

    // Model: playback is a queue of samples still owed from the current word,
    // plus flags for "stopped", "read outstanding" and "finished".
    bit            m_stop, m_req, m_wait, m_fin, m_pend, m_under, m_en;
    logic [SW-1:0] m_out;
    logic [SW-1:0] m_q [$];
    int            m_addr, m_rd_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_stop = 1; m_req = 0; m_wait = 0; m_fin = 0; m_pend = 0; m_under = 0; m_en = 0;
        m_q.delete();
        m_addr = int'(START);
    endtask

    task automatic rewind(input bit rv);
        m_addr = rv ? int'(ENDA) : int'(START);
        m_q.delete();
        m_stop = 1; m_req = 0; m_wait = 0; m_fin = 0; m_pend = 0;
    endtask

    task automatic advance(input bit rv, input bit lp);
        if ((!rv && m_addr == int'(ENDA)) || (rv && m_addr == int'(START))) begin
            if (lp) begin
                m_addr = rv ? int'(ENDA) : int'(START);
                m_req  = 1;
            end else begin
                m_fin = 1;
            end
        end else begin
            m_addr = rv ? m_addr - 1 : m_addr + 1;
            m_req  = 1;
        end
    endtask

    task automatic model_step(input bit tk, pl, rv, lp, rs, wr, rdv, input logic [DW-1:0] rd);
        m_en = 0;
        if (m_fin) begin
            if (rs) rewind(rv);
        end else if (m_stop) begin
            if (rs) rewind(rv);
            else if (pl) begin m_stop = 0; m_req = 1; end
        end else if (m_req) begin
            if (tk && pl) m_under = 1;
            if (rs) m_pend = 1;
            if (!wr) begin m_req = 0; m_wait = 1; m_rd_addr = m_addr; end
        end else if (m_wait) begin
            if (tk && pl) m_under = 1;
            if (rdv) begin
                m_wait = 0;
                if (m_pend || rs) rewind(rv);
                else for (int k = 0; k < NS; k++)
                    m_q.push_back(rd[(rv ? NS-1-k : k)*SW +: SW]);
            end else if (rs) m_pend = 1;
        end else begin
            if (rs) rewind(rv);
            else if (tk && pl) begin
                m_out = m_q.pop_front();
                m_en  = 1;
                if (m_q.size() == 0) advance(rv, lp);
            end
        end
    endtask

    task automatic compare();
        chk("flsh_read", flsh_read, m_req);
        if (m_req || m_stop) chk("flsh_address", flsh_address, m_addr);
        chk("audio_enable", audio_enable, m_en);
        if (m_en) chk("audio_out", audio_out, m_out);
        chk("done", done, m_fin);
        chk("underrun", underrun, m_under);
        chk("byteenable", flsh_byteenable, 4'hF);
    endtask

    task automatic step(input bit tk, pl, rv, lp, rs, wr, rdv);
        logic [DW-1:0] rd;
        rd = rdv ? mem[m_rd_addr[1:0]] : DW'($urandom);
        sample_tick = tk; play = pl; reverse = rv; loop = lp; restart = rs;
        flsh_waitrequest = wr; flsh_readdatavalid = rdv; flsh_readdata = rd;
        #1;
        if (flsh_read && flsh_address == m_addr[AW-1:0]) begin
            n_rd_cyc++;
            if (!wr) n_acc++;
        end
        @(posedge clk);
        model_step(tk, pl, rv, lp, rs, wr, rdv, rd);
        @(negedge clk);
        compare();
        if (audio_enable) n_en++;
    endtask

    task automatic do_reset();
        sample_tick = 0; play = 0; reverse = 0; loop = 0; restart = 0;
        flsh_waitrequest = 0; flsh_readdatavalid = 0; flsh_readdata = '0;
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        model_reset();
        compare();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  en0, cnt;
        bit  r_rev, r_lp, seen;
        for (int i = 0; i < 4; i++) mem[i] = DW'($urandom);
        mem[0] = 32'hBBBBAAAA;
        mem[3] = 32'hBBBBAAAA;
        do_reset();
        chk("rst_audio_out", audio_out, 0);
        chk("rst_address", flsh_address, 0);

        // Forward word, read held by waitrequest for three cycles.
        n_rd_cyc = 0; n_acc = 0; n_en = 0;
        step(0, 1, 0, 1, 0, 1, 0);
        repeat (3) step(0, 1, 0, 1, 0, 1, 0);
        step(0, 1, 0, 1, 0, 0, 0);
        chk("wait_read_cycles", n_rd_cyc, 4);
        chk("wait_one_read", n_acc, 1);
        step(0, 1, 0, 1, 0, 0, 1);
        step(1, 1, 0, 1, 0, 0, 0);
        chk("fwd_first", audio_out, 16'hAAAA);
        step(1, 1, 0, 1, 0, 0, 0);
        chk("fwd_second", audio_out, 16'hBBBB);
        chk("fwd_next_addr", flsh_address, 1);
        chk("fwd_enables", n_en, 2);

        // Restart latched in FETCH, word discarded, rewind to END for reverse.
        en0 = n_en;
        step(0, 1, 1, 1, 1, 0, 0);
        step(0, 1, 1, 1, 0, 0, 0);
        step(0, 1, 1, 1, 0, 0, 1);
        chk("restart_no_emit", n_en, en0);
        chk("restart_addr", flsh_address, 3);

        step(0, 1, 1, 1, 0, 0, 0);
        step(0, 1, 1, 1, 0, 0, 0);
        step(0, 1, 1, 1, 0, 0, 1);
        step(1, 1, 1, 1, 0, 0, 0);
        chk("rev_first", audio_out, 16'hBBBB);
        step(1, 1, 1, 1, 0, 0, 0);
        chk("rev_second", audio_out, 16'hAAAA);
        chk("rev_next_addr", flsh_address, 2);

        // Tick held across a slow data return.
        en0 = n_en;
        step(1, 1, 1, 1, 0, 0, 0);
        repeat (5) step(1, 1, 1, 1, 0, 0, 0);
        step(1, 1, 1, 1, 0, 0, 1);
        chk("underrun_set", underrun, 1);
        chk("underrun_no_emit", n_en, en0);
        step(1, 1, 1, 1, 0, 0, 0);
        chk("underrun_then_play", audio_out, mem[2][31:16]);

        // Bounded forward pass through the whole window without loop.
        do_reset();
        for (int i = 0; i < 4; i++) mem[i] = DW'($urandom);
        n_en = 0; cnt = -1; seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            step(1, 1, 0, 0, 0, 1'($urandom_range(0, 1)), m_wait && ($urandom_range(0, 2) == 0));
            if (done) begin seen = 1; cnt = n_en; chk("done_with_last", audio_enable, 1); end
        end
        chk("done_after_8", cnt, 8);
        repeat (3) step(1, 1, 0, 0, 0, 0, 0);
        chk("done_sticky", done, 1);
        step(0, 0, 0, 0, 1, 0, 0);
        chk("done_restart_addr", flsh_address, 0);
        chk("done_cleared", done, 0);

        // Reset mid-transaction, then a stray readdatavalid.
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        do_reset();
        step(0, 0, 0, 0, 0, 0, 1);
        chk("late_valid_ignored", audio_enable, 0);

        // Random phase.
        r_rev = 0; r_lp = 1;
        for (int i = 0; i < 4; i++) mem[i] = DW'($urandom);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 29) == 0) r_rev = ~r_rev;
            if ($urandom_range(0, 29) == 0) r_lp = ~r_lp;
            if ($urandom_range(0, 999) == 0) do_reset();
            step(1'($urandom_range(0, 1)), $urandom_range(0, 7) != 0, r_rev, r_lp,
                 $urandom_range(0, 49) == 0, 1'($urandom_range(0, 1)),
                 m_wait && ($urandom_range(0, 2) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
